// File: rtl/home_event_scheduler.sv
// Prioritised, time-sliced scheduler for the smart-home actuators.
// Door and window edges are queued; fire preempts everything; heat/cool follow the live temperature.
module home_event_scheduler #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter logic [6:0]  TEMP_LOW    = 7'd20,
  parameter logic [6:0]  TEMP_HIGH   = 7'd25
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SW,
  input  logic       SFA,
  input  logic [6:0] ST,
  output logic       fdoor,
  output logic       rdoor,
  output logic       winbuzz,
  output logic       alarmbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic [2:0] pending,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FRONT = 3'b001,
    REAR  = 3'b010,
    WIN   = 3'b011,
    FIRE  = 3'b100,
    HEAT  = 3'b101,
    COOL  = 3'b110
  } state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [2:0]  pending_q;
  logic [2:0]  prev_q;
  logic [2:0]  sensors;
  logic [2:0]  rise;
  logic [2:0]  clear;
  logic        heat_req;
  logic        cool_req;
  logic        in_band;
  logic        hold_done;

  assign sensors   = {SW, SRD, SFD};
  assign rise      = sensors & ~prev_q;
  assign heat_req  = (ST < TEMP_LOW);
  assign cool_req  = (ST > TEMP_HIGH);
  assign in_band   = !heat_req && !cool_req;
  assign hold_done = (cnt_q == 16'd0);

  // A pending bit clears only when its service ends normally; preemption leaves it queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 3'b000;
    if (SFA) begin
      state_d = FIRE;
      cnt_d   = HOLD_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = HOLD_LOAD;
          if (pending_q[0])      state_d = FRONT;
          else if (pending_q[1]) state_d = REAR;
          else if (pending_q[2]) state_d = WIN;
          else if (heat_req)     state_d = HEAT;
          else if (cool_req)     state_d = COOL;
          else                   cnt_d   = 16'd0;
        end
        FRONT: begin
          if (hold_done) begin
            state_d = IDLE;
            clear   = 3'b001;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        REAR: begin
          if (hold_done) begin
            state_d = IDLE;
            clear   = 3'b010;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        WIN: begin
          if (hold_done) begin
            state_d = IDLE;
            clear   = 3'b100;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        FIRE: begin
          if (hold_done) state_d = IDLE;
          else           cnt_d   = cnt_q - 16'd1;
        end
        HEAT, COOL: begin
          if (in_band || hold_done) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  // Prev registers track live inputs even in reset so a level held across release is not an event.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      pending_q <= 3'b000;
      prev_q    <= sensors;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= (pending_q & ~clear) | rise;
      prev_q    <= sensors;
    end
  end

  always_comb begin
    fdoor     = (state_q == FRONT);
    rdoor     = (state_q == REAR);
    winbuzz   = (state_q == WIN);
    alarmbuzz = (state_q == FIRE);
    heater    = (state_q == HEAT);
    cooler    = (state_q == COOL);
    display   = state_q;
    pending   = pending_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_home_event_scheduler.sv
// Self-checking bench for home_event_scheduler: vector table, directed corner sequences,
// and randomized traffic scored against a service-level reference model.
module tb_home_event_scheduler;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic       sfd;
  logic       srd;
  logic       sw;
  logic       sfa;
  logic [6:0] st;
  logic       fdoor;
  logic       rdoor;
  logic       winbuzz;
  logic       alarmbuzz;
  logic       heater;
  logic       cooler;
  logic [2:0] display;
  logic [2:0] pending;
  logic       busy;
  logic [12:0] obs;

  int n_compared;
  int n_mismatched;

  // Reference model: which service is active and how many cycles it still has.
  int       m_svc;
  int       m_left;
  bit [2:0] m_pend;
  bit [2:0] m_prev;

  typedef struct packed {
    logic       rst;
    logic       sfd;
    logic       srd;
    logic       sw;
    logic       sfa;
    logic [6:0] st;
    logic [2:0] exp_disp;
    logic [2:0] exp_pend;
  } vec_t;

  vec_t vecs[$];

  home_event_scheduler #(
    .HOLD_CYCLES(HOLD),
    .TEMP_LOW(7'd20),
    .TEMP_HIGH(7'd25)
  ) dut (
    .clk(clk),
    .Rst(rst),
    .SFD(sfd),
    .SRD(srd),
    .SW(sw),
    .SFA(sfa),
    .ST(st),
    .fdoor(fdoor),
    .rdoor(rdoor),
    .winbuzz(winbuzz),
    .alarmbuzz(alarmbuzz),
    .heater(heater),
    .cooler(cooler),
    .display(display),
    .pending(pending),
    .busy(busy)
  );

  assign obs = {fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, display, pending, busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] act_of(input logic [2:0] d);
    case (d)
      3'd1:    return 6'b100000;
      3'd2:    return 6'b010000;
      3'd3:    return 6'b001000;
      3'd4:    return 6'b000100;
      3'd5:    return 6'b000010;
      3'd6:    return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [12:0] pack_exp(input logic [2:0] d, input logic [2:0] p);
    return {act_of(d), d, p, (d != 3'd0)};
  endfunction

  task automatic model_step();
    bit [2:0] in_now;
    bit [2:0] rise_now;
    bit [2:0] clr;
    in_now = {sw, srd, sfd};
    if (rst) begin
      m_svc  = 0;
      m_left = 0;
      m_pend = 3'b000;
      m_prev = in_now;
      return;
    end
    rise_now = in_now & ~m_prev;
    m_prev   = in_now;
    clr      = 3'b000;
    if (sfa) begin
      m_svc  = 4;
      m_left = HOLD;
    end else if (m_svc == 0) begin
      if (m_pend[0])      m_svc = 1;
      else if (m_pend[1]) m_svc = 2;
      else if (m_pend[2]) m_svc = 3;
      else if (st < 20)   m_svc = 5;
      else if (st > 25)   m_svc = 6;
      m_left = HOLD;
    end else if ((m_svc == 5 || m_svc == 6) && st >= 20 && st <= 25) begin
      m_svc = 0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_svc >= 1 && m_svc <= 3) clr[m_svc-1] = 1'b1;
        m_svc = 0;
      end
    end
    m_pend = (m_pend & ~clr) | rise_now;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic fd, input logic rd, input logic w,
                               input logic fa, input logic [6:0] t);
    rst = r;
    sfd = fd;
    srd = rd;
    sw  = w;
    sfa = fa;
    st  = t;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] expected);
    n_compared++;
    if (obs !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got {act,disp,pend,busy}=%b expected %b at %0t", name, obs, expected, $time);
    end
  endtask

  task automatic chk(input string name, input logic [2:0] d, input logic [2:0] p);
    checkOutput(name, pack_exp(d, p));
  endtask

  task automatic add_row(input logic r, input logic fd, input logic rd, input logic w, input logic fa,
                         input logic [6:0] t, input logic [2:0] d, input logic [2:0] p);
    vec_t v;
    v.rst = r; v.sfd = fd; v.srd = rd; v.sw = w; v.sfa = fa; v.st = t;
    v.exp_disp = d; v.exp_pend = p;
    vecs.push_back(v);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_svc = 0; m_left = 0; m_pend = 3'b000; m_prev = 3'b000;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd22);

    // Reset with front door held high, then release: no event.
    add_row(1, 1, 0, 0, 0, 7'd22, 3'd0, 3'b000);
    add_row(1, 1, 0, 0, 0, 7'd22, 3'd0, 3'b000);
    add_row(0, 1, 0, 0, 0, 7'd22, 3'd0, 3'b000);
    add_row(0, 1, 0, 0, 0, 7'd22, 3'd0, 3'b000);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd0, 3'b000);
    // Front door rise: pending, then four FRONT cycles, then IDLE with the bit cleared.
    add_row(0, 1, 0, 0, 0, 7'd22, 3'd0, 3'b001);
    add_row(0, 1, 0, 0, 0, 7'd22, 3'd1, 3'b001);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd1, 3'b001);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd1, 3'b001);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd1, 3'b001);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd0, 3'b000);
    // Rear and window together: REAR x4, IDLE, WIN x4, IDLE.
    add_row(0, 0, 1, 1, 0, 7'd22, 3'd0, 3'b110);
    add_row(0, 0, 1, 1, 0, 7'd22, 3'd2, 3'b110);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd2, 3'b110);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd2, 3'b110);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd2, 3'b110);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd0, 3'b100);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd3, 3'b100);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd3, 3'b100);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd3, 3'b100);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd3, 3'b100);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd0, 3'b000);
    add_row(0, 0, 0, 0, 0, 7'd22, 3'd0, 3'b000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].sfd, vecs[i].srd, vecs[i].sw, vecs[i].sfa, vecs[i].st);
      cycle();
      checkOutput($sformatf("row%0d", i), pack_exp(vecs[i].exp_disp, vecs[i].exp_pend));
    end

    // Fire preempts REAR in its second cycle; REAR is re-served afterwards.
    applyStimulus(0, 0, 1, 0, 0, 7'd22); cycle(); chk("fire_pend", 3'd0, 3'b010);
    applyStimulus(0, 0, 0, 0, 0, 7'd22); cycle(); chk("rear_1", 3'd2, 3'b010);
    cycle(); chk("rear_2", 3'd2, 3'b010);
    applyStimulus(0, 0, 0, 0, 1, 7'd22);
    for (int i = 0; i < 3; i++) begin cycle(); chk("fire_held", 3'd4, 3'b010); end
    applyStimulus(0, 0, 0, 0, 0, 7'd22);
    for (int i = 0; i < 3; i++) begin cycle(); chk("fire_tail", 3'd4, 3'b010); end
    cycle(); chk("fire_idle", 3'd0, 3'b010);
    for (int i = 0; i < 4; i++) begin cycle(); chk("rear_again", 3'd2, 3'b010); end
    cycle(); chk("rear_done", 3'd0, 3'b000);

    // Heat with early exit, then cool running its full hold and being re-granted.
    applyStimulus(0, 0, 0, 0, 0, 7'd15);
    cycle(); chk("heat_1", 3'd5, 3'b000);
    cycle(); chk("heat_2", 3'd5, 3'b000);
    applyStimulus(0, 0, 0, 0, 0, 7'd22); cycle(); chk("heat_exit", 3'd0, 3'b000);
    applyStimulus(0, 0, 0, 0, 0, 7'd30);
    for (int i = 0; i < 4; i++) begin cycle(); chk("cool", 3'd6, 3'b000); end
    cycle(); chk("cool_gap", 3'd0, 3'b000);
    cycle(); chk("cool_regrant", 3'd6, 3'b000);
    applyStimulus(0, 0, 0, 0, 0, 7'd22); cycle(); chk("cool_exit", 3'd0, 3'b000);

    // New front edge on the cycle the front bit clears: set wins.
    applyStimulus(0, 1, 0, 0, 0, 7'd22); cycle(); chk("col_pend", 3'd0, 3'b001);
    applyStimulus(0, 0, 0, 0, 0, 7'd22);
    for (int i = 0; i < 4; i++) begin cycle(); chk("col_front", 3'd1, 3'b001); end
    applyStimulus(0, 1, 0, 0, 0, 7'd22); cycle(); chk("col_setwins", 3'd0, 3'b001);
    applyStimulus(0, 0, 0, 0, 0, 7'd22);
    for (int i = 0; i < 4; i++) begin cycle(); chk("col_reserve", 3'd1, 3'b001); end
    cycle(); chk("col_done", 3'd0, 3'b000);

    // Reset mid-FRONT with the window request queued.
    applyStimulus(0, 1, 0, 1, 0, 7'd22); cycle(); chk("rst_pend", 3'd0, 3'b101);
    cycle(); chk("rst_front3", 3'd1, 3'b101);
    cycle(); chk("rst_front2", 3'd1, 3'b101);
    applyStimulus(1, 1, 0, 1, 0, 7'd22); cycle(); chk("rst_mid", 3'd0, 3'b000);
    applyStimulus(0, 1, 0, 1, 0, 7'd22); cycle(); chk("rst_release", 3'd0, 3'b000);
    applyStimulus(0, 0, 0, 0, 0, 7'd22); cycle(); chk("rst_quiet", 3'd0, 3'b000);

    // Randomized traffic against the reference model.
    applyStimulus(1, 0, 0, 0, 0, 7'd22); cycle(); cycle();
    for (int i = 0; i < 1500; i++) begin
      logic       r_rst, r_sfd, r_srd, r_sw, r_sfa;
      logic [6:0] r_st;
      r_rst = ($urandom_range(199) == 0);
      r_sfd = ($urandom_range(7) == 0) ? ~sfd : sfd;
      r_srd = ($urandom_range(7) == 0) ? ~srd : srd;
      r_sw  = ($urandom_range(7) == 0) ? ~sw : sw;
      if (sfa) r_sfa = ($urandom_range(3) != 0);
      else     r_sfa = ($urandom_range(39) == 0);
      r_st  = ($urandom_range(9) == 0) ? 7'($urandom_range(35, 10)) : st;
      applyStimulus(r_rst, r_sfd, r_srd, r_sw, r_sfa, r_st);
      cycle();
      checkOutput("rand", pack_exp(3'(m_svc), m_pend));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
